rd_next_id: RTL and testbench
=============================

RD_NEXT_ID -- requirements
Module: rd_next_id

Interface
REQ-001 SHALL have parameter WEI_CYC_W, default 12, cycle-count width for weight and weight-flag channels.
REQ-002 SHALL have parameter ACT_CYC_W, default 8, cycle-count width for activation and activation-flag channels.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 SRAM_config_start  input  1  one-cycle pulse; latches configuration and starts all four channels.
REQ-006 CFGGB_SRAM_num_{wei,flgwei,act,flgact}  input  4 each  banks allocated per channel.
REQ-007 CFGGB_Data_num_{wei,flgwei,act,flgact}  input  4 each  words read per bank before advancing.
REQ-008 CFGGB_Cycl_num_{wei,flgwei}  input  WEI_CYC_W each  full passes over the allocation.
REQ-009 CFGGB_Cycl_num_{act,flgact}  input  ACT_CYC_W each  full passes over the allocation.
REQ-010 Rd_Req  input  4  per-channel level request, bit0=wei, 1=flgwei, 2=act, 3=flgact; one word per granted cycle.
REQ-011 Rd_Ready_g  input  16  bit k high = absolute bank k holds valid data.
REQ-012 SRAMIF_Rd_en  output  1  registered read strobe.
REQ-013 SRAMIF_Rd_ID  output  6  registered {type[1:0], abs_bank[3:0]}.
REQ-014 Rd_Gnt  output  4  registered one-hot channel served this cycle.
REQ-015 Rd_Release_en / Rd_Release_ID  output  1 / 4  registered pulse and abs bank fully drained.
REQ-016 read_Cyc_done_{Wei,WeiFlg,Act,ActFlg}  output  1 each  registered pulse on final read of the channel.

Function
REQ-017 Config registers SHALL latch on SRAM_config_start; mid-run config input changes ignored.
REQ-018 Abs bank base: wei 0; flgwei = S_wei; act = S_wei+S_flgwei; flgact = S_wei+S_flgwei+S_act; abs = base+cor_bank, 4-bit, wrap mod 16.
REQ-019 Per-channel FSM IDLE/RUN; start -> RUN with data_cnt, bank_cnt, cyc_cnt = 0.
REQ-020 Start while channel has zero SRAM_num, Data_num or Cycl_num: no reads; done pulse next cycle; stay IDLE.
REQ-021 Eligible = RUN & Rd_Req[ch] & Rd_Ready_g[abs_bank(ch)].
REQ-022 Round-robin arbitration among eligible channels; pointer moves to channel after the one granted; reset pointer = channel 0.
REQ-023 Grant at edge N: SRAMIF_Rd_en=1, Rd_ID, Rd_Gnt valid in cycle N+1 (1-cycle latency); no eligible -> Rd_en=0, Rd_Gnt=0, Rd_ID holds.
REQ-024 On grant: data_cnt++; at Data_num-1 wrap to 0, bank_cnt++, Rd_Release pulse with this bank's abs ID.
REQ-025 bank_cnt wraps at SRAM_num-1 with cyc_cnt++; cyc_cnt reaching Cycl_num-1 with bank/data wrap -> done pulse, channel -> IDLE.
REQ-026 Final read's Rd_en, Rd_Release_en and done SHALL be asserted in the same cycle.
REQ-027 Start coincident with a grant or done: start wins; counters restart; that grant/done suppressed.
REQ-028 Held Rd_Req with ready bank: reads back-to-back every cycle when uncontested.
REQ-029 IDLE channel SHALL never be granted regardless of Rd_Req.

Reset
REQ-030 rst SHALL force: all FSMs IDLE, counters 0, RR pointer 0, config regs 0, all outputs 0 (Rd_ID=6'h00).
REQ-031 rst asserted mid-run SHALL abort reads with no done or release pulse; restart requires new start.

Verification
REQ-032 S_wei=2, D_wei=3, C_wei=1, Rd_Req=0001, all ready -> 6 Rd_en cycles, IDs 00,00,00,01,01,01, release at reads 3 and 6, done_Wei on read 6.
REQ-033 S_wei=2,S_flgwei=1,S_act=3,S_flgact=1; act at start -> first Rd_ID = {10, 4'd3}; flgact -> {11, 4'd6}.
REQ-034 All four requesting, all ready -> Rd_Gnt order 0001,0010,0100,1000,0001.
REQ-035 Rd_Ready_g[0]=0 with wei requesting -> no Rd_en; ready raised -> Rd_en one cycle later.
REQ-036 Start repeated mid-run -> counters restart, next Rd_ID returns to bank base.
REQ-037 D_act=0 at start -> no act reads, read_Cyc_done_Act pulses next cycle; rst mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rd_next_id.sv
// Read-request arbiter for the global-buffer SRAM banks: four channels
// (wei, flgwei, act, flgact) walk their bank allocation and share one read port.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   SRAM_config_start          pulse: latch configuration, start all channels
//   CFGGB_SRAM_num_*           banks allocated per channel
//   CFGGB_Data_num_*           words read per bank before advancing
//   CFGGB_Cycl_num_*           full passes over the allocation
//   Rd_Req                     per-channel request (0=wei 1=flgwei 2=act 3=flgact)
//   Rd_Ready_g                 per absolute bank data-valid flags
//   SRAMIF_Rd_en / _Rd_ID      registered read strobe and {type, abs_bank}
//   Rd_Gnt                     registered one-hot grant
//   Rd_Release_en / _ID        registered pulse when a bank is fully drained
//   read_Cyc_done_*            registered pulse on a channel's final read
module rd_next_id #(
  parameter int WEI_CYC_W = 12,
  parameter int ACT_CYC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SRAM_config_start,
  input  logic [3:0]           CFGGB_SRAM_num_wei,
  input  logic [3:0]           CFGGB_SRAM_num_flgwei,
  input  logic [3:0]           CFGGB_SRAM_num_act,
  input  logic [3:0]           CFGGB_SRAM_num_flgact,
  input  logic [3:0]           CFGGB_Data_num_wei,
  input  logic [3:0]           CFGGB_Data_num_flgwei,
  input  logic [3:0]           CFGGB_Data_num_act,
  input  logic [3:0]           CFGGB_Data_num_flgact,
  input  logic [WEI_CYC_W-1:0] CFGGB_Cycl_num_wei,
  input  logic [WEI_CYC_W-1:0] CFGGB_Cycl_num_flgwei,
  input  logic [ACT_CYC_W-1:0] CFGGB_Cycl_num_act,
  input  logic [ACT_CYC_W-1:0] CFGGB_Cycl_num_flgact,
  input  logic [3:0]           Rd_Req,
  input  logic [15:0]          Rd_Ready_g,
  output logic                 SRAMIF_Rd_en,
  output logic [5:0]           SRAMIF_Rd_ID,
  output logic [3:0]           Rd_Gnt,
  output logic                 Rd_Release_en,
  output logic [3:0]           Rd_Release_ID,
  output logic                 read_Cyc_done_Wei,
  output logic                 read_Cyc_done_WeiFlg,
  output logic                 read_Cyc_done_Act,
  output logic                 read_Cyc_done_ActFlg
);

  localparam int CW = (WEI_CYC_W > ACT_CYC_W) ?
                      WEI_CYC_W : ACT_CYC_W;

  typedef enum logic {IDLE, RUN} st_e;

  logic start;
  assign start = SRAM_config_start;

  // Configuration inputs gathered per channel
  logic [3:0]    s_in [4];
  logic [3:0]    d_in [4];
  logic [CW-1:0] c_in [4];
  logic [3:0]    zero_in;

  always_comb begin
    s_in[0] = CFGGB_SRAM_num_wei;
    s_in[1] = CFGGB_SRAM_num_flgwei;
    s_in[2] = CFGGB_SRAM_num_act;
    s_in[3] = CFGGB_SRAM_num_flgact;
    d_in[0] = CFGGB_Data_num_wei;
    d_in[1] = CFGGB_Data_num_flgwei;
    d_in[2] = CFGGB_Data_num_act;
    d_in[3] = CFGGB_Data_num_flgact;
    c_in[0] = CW'(CFGGB_Cycl_num_wei);
    c_in[1] = CW'(CFGGB_Cycl_num_flgwei);
    c_in[2] = CW'(CFGGB_Cycl_num_act);
    c_in[3] = CW'(CFGGB_Cycl_num_flgact);
    for (int ch = 0; ch < 4; ch++) begin
      zero_in[ch] = (s_in[ch] == 4'd0) ||
                    (d_in[ch] == 4'd0) ||
                    (c_in[ch] == '0);
    end
  end

  // Latched configuration
  logic [3:0]    s_q [4];
  logic [3:0]    d_q [4];
  logic [CW-1:0] c_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        s_q[ch] <= '0;
        d_q[ch] <= '0;
        c_q[ch] <= '0;
      end
    end else if (start) begin
      for (int ch = 0; ch < 4; ch++) begin
        s_q[ch] <= s_in[ch];
        d_q[ch] <= d_in[ch];
        c_q[ch] <= c_in[ch];
      end
    end
  end

  // Channel state and counters
  st_e           st_q   [4];
  st_e           st_d   [4];
  logic [3:0]    dcnt_q [4];
  logic [3:0]    dcnt_d [4];
  logic [3:0]    bcnt_q [4];
  logic [3:0]    bcnt_d [4];
  logic [CW-1:0] ccnt_q [4];
  logic [CW-1:0] ccnt_d [4];
  logic [1:0]    ptr_q, ptr_d;

  // Banks are packed back to back in channel order; sums wrap mod 16.
  logic [3:0] base    [4];
  logic [3:0] abs_bnk [4];
  logic [3:0] elig;
  logic [3:0] d_last, b_last, c_last, last;

  always_comb begin
    base[0] = 4'd0;
    base[1] = s_q[0];
    base[2] = s_q[0] + s_q[1];
    base[3] = s_q[0] + s_q[1] + s_q[2];
    for (int ch = 0; ch < 4; ch++) begin
      abs_bnk[ch] = base[ch] + bcnt_q[ch];
      elig[ch]    = (st_q[ch] == RUN) && Rd_Req[ch] &&
                    Rd_Ready_g[abs_bnk[ch]];
      d_last[ch]  = (dcnt_q[ch] == d_q[ch] - 4'd1);
      b_last[ch]  = (bcnt_q[ch] == s_q[ch] - 4'd1);
      c_last[ch]  = (ccnt_q[ch] == c_q[ch] - CW'(1));
      last[ch]    = d_last[ch] && b_last[ch] && c_last[ch];
    end
  end

  // Round-robin: first eligible channel at or after the pointer
  logic       gnt_vld;
  logic [1:0] gidx;
  logic [1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gidx    = ptr_q;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gidx    = idx;
      end
    end
  end

  // A start on the same edge overrides any grant in flight.
  logic take;
  assign take = gnt_vld && !start;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) st_q[ch] <= IDLE;
    end else begin
      for (int ch = 0; ch < 4; ch++) st_q[ch] <= st_d[ch];
    end
  end

  // FSM next state
  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      st_d[ch] = st_q[ch];
      if (start) begin
        st_d[ch] = zero_in[ch] ? IDLE : RUN;
      end else if (take && gidx == 2'(ch) && last[ch]) begin
        st_d[ch] = IDLE;
      end
    end
  end

  // Counter datapath
  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      dcnt_d[ch] = dcnt_q[ch];
      bcnt_d[ch] = bcnt_q[ch];
      ccnt_d[ch] = ccnt_q[ch];
      if (start) begin
        dcnt_d[ch] = '0;
        bcnt_d[ch] = '0;
        ccnt_d[ch] = '0;
      end else if (take && gidx == 2'(ch)) begin
        if (d_last[ch]) begin
          dcnt_d[ch] = '0;
          if (b_last[ch]) begin
            bcnt_d[ch] = '0;
            ccnt_d[ch] = c_last[ch] ? '0 : ccnt_q[ch] + CW'(1);
          end else begin
            bcnt_d[ch] = bcnt_q[ch] + 4'd1;
          end
        end else begin
          dcnt_d[ch] = dcnt_q[ch] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        dcnt_q[ch] <= '0;
        bcnt_q[ch] <= '0;
        ccnt_q[ch] <= '0;
      end
      ptr_q <= '0;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        dcnt_q[ch] <= dcnt_d[ch];
        bcnt_q[ch] <= bcnt_d[ch];
        ccnt_q[ch] <= ccnt_d[ch];
      end
      ptr_q <= ptr_d;
    end
  end

  // Output logic (next values of the registered outputs)
  logic       rd_en_q, rd_en_d;
  logic [5:0] id_q, id_d;
  logic [3:0] gnt_q, gnt_d;
  logic       rel_en_q, rel_en_d;
  logic [3:0] rel_id_q, rel_id_d;
  logic [3:0] done_q, done_d;

  always_comb begin
    rd_en_d  = 1'b0;
    id_d     = id_q;
    gnt_d    = '0;
    rel_en_d = 1'b0;
    rel_id_d = rel_id_q;
    done_d   = '0;
    ptr_d    = ptr_q;
    if (start) begin
      // Channels with an empty allocation finish immediately.
      done_d = zero_in;
    end else if (gnt_vld) begin
      rd_en_d     = 1'b1;
      id_d        = {gidx, abs_bnk[gidx]};
      gnt_d[gidx] = 1'b1;
      ptr_d       = gidx + 2'd1;
      if (d_last[gidx]) begin
        rel_en_d = 1'b1;
        rel_id_d = abs_bnk[gidx];
      end
      if (last[gidx]) done_d[gidx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q  <= 1'b0;
      id_q     <= '0;
      gnt_q    <= '0;
      rel_en_q <= 1'b0;
      rel_id_q <= '0;
      done_q   <= '0;
    end else begin
      rd_en_q  <= rd_en_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      rel_en_q <= rel_en_d;
      rel_id_q <= rel_id_d;
      done_q   <= done_d;
    end
  end

  assign SRAMIF_Rd_en         = rd_en_q;
  assign SRAMIF_Rd_ID         = id_q;
  assign Rd_Gnt               = gnt_q;
  assign Rd_Release_en        = rel_en_q;
  assign Rd_Release_ID        = rel_id_q;
  assign read_Cyc_done_Wei    = done_q[0];
  assign read_Cyc_done_WeiFlg = done_q[1];
  assign read_Cyc_done_Act    = done_q[2];
  assign read_Cyc_done_ActFlg = done_q[3];

endmodule

// File: tb/tb_rd_next_id.sv
// Scoreboard bench for rd_next_id: directed configurations, expected
// output events queued at stimulus time and checked by a negedge monitor.
module tb_rd_next_id;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  s_w = 0, s_fw = 0, s_a = 0, s_fa = 0;
  logic [3:0]  d_w = 0, d_fw = 0, d_a = 0, d_fa = 0;
  logic [11:0] c_w = 0, c_fw = 0;
  logic [7:0]  c_a = 0, c_fa = 0;
  logic [3:0]  req = 0;
  logic [15:0] rdy = 0;
  logic        rd_en;
  logic [5:0]  rd_id;
  logic [3:0]  gnt;
  logic        rel_en;
  logic [3:0]  rel_id;
  logic        dn_w, dn_fw, dn_a, dn_fa;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rd_next_id #(.WEI_CYC_W(12), .ACT_CYC_W(8)) dut (
    .clk(clk), .rst(rst), .SRAM_config_start(start),
    .CFGGB_SRAM_num_wei(s_w), .CFGGB_SRAM_num_flgwei(s_fw),
    .CFGGB_SRAM_num_act(s_a), .CFGGB_SRAM_num_flgact(s_fa),
    .CFGGB_Data_num_wei(d_w), .CFGGB_Data_num_flgwei(d_fw),
    .CFGGB_Data_num_act(d_a), .CFGGB_Data_num_flgact(d_fa),
    .CFGGB_Cycl_num_wei(c_w), .CFGGB_Cycl_num_flgwei(c_fw),
    .CFGGB_Cycl_num_act(c_a), .CFGGB_Cycl_num_flgact(c_fa),
    .Rd_Req(req), .Rd_Ready_g(rdy),
    .SRAMIF_Rd_en(rd_en), .SRAMIF_Rd_ID(rd_id), .Rd_Gnt(gnt),
    .Rd_Release_en(rel_en), .Rd_Release_ID(rel_id),
    .read_Cyc_done_Wei(dn_w), .read_Cyc_done_WeiFlg(dn_fw),
    .read_Cyc_done_Act(dn_a), .read_Cyc_done_ActFlg(dn_fa)
  );

  typedef struct packed {
    logic       rd_en;
    logic [5:0] id;
    logic [3:0] gnt;
    logic       rel_en;
    logic [3:0] rel_id;
    logic [3:0] done;
  } ev_t;

  ev_t q[$];

  function automatic ev_t rd(input logic [5:0] id, input logic [3:0] g,
                             input logic re, input logic [3:0] ri,
                             input logic [3:0] dn);
    ev_t e;
    e.rd_en = 1'b1; e.id = id; e.gnt = g;
    e.rel_en = re; e.rel_id = ri; e.done = dn;
    return e;
  endfunction

  function automatic ev_t dne(input logic [3:0] dn);
    ev_t e;
    e = '0;
    e.done = dn;
    return e;
  endfunction

  // Monitor: every cycle carrying a read, release or done pops one entry.
  always @(negedge clk) begin
    logic [3:0] dn;
    ev_t e;
    logic ok;
    dn = {dn_fa, dn_a, dn_fw, dn_w};
    if (rd_en || rel_en || dn != 4'd0) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event t=%0t rd_en=%b id=%h gnt=%b rel=%b/%h done=%b required none",
                 $time, rd_en, rd_id, gnt, rel_en, rel_id, dn);
      end else begin
        e = q.pop_front();
        ok = (rd_en == e.rd_en) && (rel_en == e.rel_en) && (dn == e.done);
        if (e.rd_en) ok = ok && (rd_id == e.id) && (gnt == e.gnt);
        if (e.rel_en) ok = ok && (rel_id == e.rel_id);
        if (!ok) begin
          miscompares++;
          $display("FAIL event t=%0t got rd_en=%b id=%h gnt=%b rel=%b/%h done=%b required rd_en=%b id=%h gnt=%b rel=%b/%h done=%b",
                   $time, rd_en, rd_id, gnt, rel_en, rel_id, dn,
                   e.rd_en, e.id, e.gnt, e.rel_en, e.rel_id, e.done);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] s, input logic [15:0] d,
                         input logic [11:0] cw, input logic [11:0] cfw,
                         input logic [7:0] ca, input logic [7:0] cfa);
    s_w = s[3:0]; s_fw = s[7:4]; s_a = s[11:8]; s_fa = s[15:12];
    d_w = d[3:0]; d_fw = d[7:4]; d_a = d[11:8]; d_fa = d[15:12];
    c_w = cw; c_fw = cfw; c_a = ca; c_fa = cfa;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk(nm, q.size(), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_outputs",
        {rd_en, rd_id, gnt, rel_en, rel_id, dn_w, dn_fw, dn_a, dn_fa}, 0);

    // Wei only: 2 banks x 3 words x 1 pass
    set_cfg(16'h0002, 16'h0003, 12'd1, 12'd0, 8'd0, 8'd0);
    req = 4'b0001; rdy = 16'hFFFF;
    q.push_back(dne(4'b1110));
    q.push_back(rd(6'h00, 4'b0001, 1'b0, 4'h0, 4'b0000));
    q.push_back(rd(6'h00, 4'b0001, 1'b0, 4'h0, 4'b0000));
    q.push_back(rd(6'h00, 4'b0001, 1'b1, 4'h0, 4'b0000));
    q.push_back(rd(6'h01, 4'b0001, 1'b0, 4'h0, 4'b0000));
    q.push_back(rd(6'h01, 4'b0001, 1'b0, 4'h0, 4'b0000));
    q.push_back(rd(6'h01, 4'b0001, 1'b1, 4'h1, 4'b0001));
    start_pulse();
    drain("drain_wei_only");

    // All four channels, bank bases 0/2/3/6, round-robin order
    do_reset();
    set_cfg(16'h1312, 16'h1111, 12'd1, 12'd1, 8'd1, 8'd1);
    req = 4'b1111; rdy = 16'hFFFF;
    q.push_back(rd(6'h00, 4'b0001, 1'b1, 4'h0, 4'b0000));
    q.push_back(rd(6'h12, 4'b0010, 1'b1, 4'h2, 4'b0010));
    q.push_back(rd(6'h23, 4'b0100, 1'b1, 4'h3, 4'b0000));
    q.push_back(rd(6'h36, 4'b1000, 1'b1, 4'h6, 4'b1000));
    q.push_back(rd(6'h01, 4'b0001, 1'b1, 4'h1, 4'b0001));
    q.push_back(rd(6'h24, 4'b0100, 1'b1, 4'h4, 4'b0000));
    q.push_back(rd(6'h25, 4'b0100, 1'b1, 4'h5, 4'b0100));
    start_pulse();
    drain("drain_round_robin");

    // Bank not ready stalls the channel until its flag rises
    do_reset();
    set_cfg(16'h0001, 16'h0002, 12'd1, 12'd0, 8'd0, 8'd0);
    req = 4'b0001; rdy = 16'hFFFE;
    q.push_back(dne(4'b1110));
    start_pulse();
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_rd_en", rd_en, 1'b0);
    q.push_back(rd(6'h00, 4'b0001, 1'b0, 4'h0, 4'b0000));
    q.push_back(rd(6'h00, 4'b0001, 1'b1, 4'h0, 4'b0001));
    rdy = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("ready_rd_en_latency", rd_en, 1'b1);
    drain("drain_ready");

    // Restart mid-run returns to the base bank
    do_reset();
    set_cfg(16'h0002, 16'h0002, 12'd2, 12'd0, 8'd0, 8'd0);
    req = 4'b0001; rdy = 16'hFFFF;
    q.push_back(dne(4'b1110));
    q.push_back(rd(6'h00, 4'b0001, 1'b0, 4'h0, 4'b0000));
    q.push_back(rd(6'h00, 4'b0001, 1'b1, 4'h0, 4'b0000));
    q.push_back(rd(6'h01, 4'b0001, 1'b0, 4'h0, 4'b0000));
    start_pulse();
    repeat (3) @(posedge clk);
    #1;
    q.push_back(dne(4'b1110));
    for (int p = 0; p < 2; p++) begin
      q.push_back(rd(6'h00, 4'b0001, 1'b0, 4'h0, 4'b0000));
      q.push_back(rd(6'h00, 4'b0001, 1'b1, 4'h0, 4'b0000));
      q.push_back(rd(6'h01, 4'b0001, 1'b0, 4'h0, 4'b0000));
      q.push_back(rd(6'h01, 4'b0001, 1'b1, 4'h1,
                     (p == 1) ? 4'b0001 : 4'b0000));
    end
    start_pulse();
    drain("drain_restart");

    // Zero Data_num on act, then reset mid-run
    do_reset();
    set_cfg(16'h0101, 16'h0004, 12'd1, 12'd0, 8'd1, 8'd0);
    req = 4'b0101; rdy = 16'hFFFF;
    q.push_back(dne(4'b1110));
    q.push_back(rd(6'h00, 4'b0001, 1'b0, 4'h0, 4'b0000));
    q.push_back(rd(6'h00, 4'b0001, 1'b0, 4'h0, 4'b0000));
    start_pulse();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset_outputs",
        {rd_en, rd_id, gnt, rel_en, rel_id, dn_w, dn_fw, dn_a, dn_fa}, 0);
    rst = 1'b0;
    drain("drain_after_reset");
    chk("idle_after_reset_rd_en", rd_en, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
